// File: rtl/draw_scheduler_pkg.sv
// Shared definitions for the draw scheduler and other frame-rate logic.
// Provides the scheduler state encoding, pixel bus widths and the
// default frame length (60 Hz at a 50 MHz clock).
package draw_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SELECT    = 3'd1,
    GRANT     = 3'd2,
    BUSY      = 3'd3,
    NEXT      = 3'd4,
    FRAME_END = 3'd5
  } state_t;

  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;
  localparam int unsigned C_W = 3;

  localparam int unsigned DEFAULT_FRAME_CYCLES = 833333;

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame timer. Counts 0..FRAME_CYCLES-1 and asserts tick
// for the single cycle in which the count equals FRAME_CYCLES-1.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset, counter returns to 0
//   tick  - one-cycle pulse once per frame
module frame_tick_gen #(
  parameter int unsigned FRAME_CYCLES = 833333
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(FRAME_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Frame-level sequencer granting the VGA adapter write port to each
// enabled drawing client in turn, once per frame tick.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   enable                - allows new frames to start
//   client_en/done/plot   - per-client enable, completion, write strobe
//   client_x/y/color      - packed per-client pixel buses
//   client_go             - one-hot one-cycle start pulse
//   vga_x/y/color/plot    - registered pixel bus to the adapter
//   active_client         - granted client index, 0 when idle
//   frame_done            - one-cycle pulse at the end of each frame
//   overrun, timeout_err  - sticky error flags
module draw_scheduler
  import draw_scheduler_pkg::*;
#(
  parameter int unsigned NUM_CLIENTS    = 4,
  parameter int unsigned FRAME_CYCLES   = DEFAULT_FRAME_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_CLIENTS-1:0]     client_en,
  input  logic [NUM_CLIENTS-1:0]     client_done,
  input  logic [NUM_CLIENTS-1:0]     client_plot,
  input  logic [X_W*NUM_CLIENTS-1:0] client_x,
  input  logic [Y_W*NUM_CLIENTS-1:0] client_y,
  input  logic [C_W*NUM_CLIENTS-1:0] client_color,
  output logic [NUM_CLIENTS-1:0]     client_go,
  output logic [X_W-1:0]             vga_x,
  output logic [Y_W-1:0]             vga_y,
  output logic [C_W-1:0]             vga_color,
  output logic                       vga_plot,
  output logic [2:0]                 active_client,
  output logic                       frame_done,
  output logic                       overrun,
  output logic                       timeout_err
);

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [15:0] wdog, wdog_nxt;
  logic        pending, pending_nxt;
  logic        overrun_nxt, timeout_nxt;
  logic        tick;

  // Per-client signals widened to 16 entries so the 4-bit idx can index
  // them directly, including idx == NUM_CLIENTS at the end of a frame.
  logic [15:0]    en_ext, done_ext, plot_ext;
  logic [X_W-1:0] xs [16];
  logic [Y_W-1:0] ys [16];
  logic [C_W-1:0] cs [16];

  frame_tick_gen #(.FRAME_CYCLES(FRAME_CYCLES)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign en_ext   = 16'(client_en);
  assign done_ext = 16'(client_done);
  assign plot_ext = 16'(client_plot);

  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      if (i < NUM_CLIENTS) begin
        xs[i] = client_x[i*X_W +: X_W];
        ys[i] = client_y[i*Y_W +: Y_W];
        cs[i] = client_color[i*C_W +: C_W];
      end else begin
        xs[i] = '0;
        ys[i] = '0;
        cs[i] = '0;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    wdog_nxt    = wdog;
    pending_nxt = pending;
    overrun_nxt = overrun;
    timeout_nxt = timeout_err;
    if (tick && pending) begin
      overrun_nxt = 1'b1;
    end
    case (state)
      IDLE: begin
        if (pending && enable) begin
          pending_nxt = 1'b0;
          idx_nxt     = '0;
          state_nxt   = SELECT;
        end
      end
      SELECT: begin
        if (idx == 4'(NUM_CLIENTS)) begin
          state_nxt = FRAME_END;
        end else if (en_ext[idx]) begin
          state_nxt = GRANT;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end
      GRANT: begin
        wdog_nxt  = '0;
        state_nxt = BUSY;
      end
      BUSY: begin
        if (done_ext[idx]) begin
          state_nxt = NEXT;
        end else if (wdog == 16'(TIMEOUT_CYCLES - 1)) begin
          timeout_nxt = 1'b1;
          state_nxt   = NEXT;
        end else begin
          wdog_nxt = wdog + 16'd1;
        end
      end
      NEXT: begin
        idx_nxt   = idx + 4'd1;
        state_nxt = SELECT;
      end
      FRAME_END: state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    // A tick wins over a same-cycle consume so it is never lost.
    if (tick) begin
      pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      wdog        <= '0;
      pending     <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      wdog        <= wdog_nxt;
      pending     <= pending_nxt;
      overrun     <= overrun_nxt;
      timeout_err <= timeout_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_x         <= '0;
      vga_y         <= '0;
      vga_color     <= '0;
      vga_plot      <= 1'b0;
      active_client <= '0;
    end else begin
      if (state == BUSY) begin
        vga_x     <= xs[idx];
        vga_y     <= ys[idx];
        vga_color <= cs[idx];
        vga_plot  <= plot_ext[idx];
      end else begin
        vga_plot <= 1'b0;
      end
      active_client <= (state_nxt == GRANT || state_nxt == BUSY) ? idx_nxt[2:0] : '0;
    end
  end

  // Decoded from state so go and frame_done drop the instant reset hits.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      client_go[i] = (state == GRANT) && (idx == 4'(i));
    end
  end

  assign frame_done = (state == FRAME_END);

endmodule
